// File: rtl/counter.sv
// Loadable terminal-count timer: after a Load edge, K rises N-1 edges later and
// holds until the next Load or reset. K comes straight from a flip-flop.
module counter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic Clk,
  input  logic rst,
  input  logic Load,
  output logic K
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] LOAD_VAL = W'(N - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  state_t         state_q;
  logic [W-1:0]   cnt_q;
  logic           k_q;

  // Load wins in every state, including unreachable encodings.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= 1'b0;
    end else if (Load) begin
      state_q <= COUNT;
      cnt_q   <= LOAD_VAL;
      k_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          k_q   <= 1'b0;
        end
        COUNT: begin
          if (cnt_q > ONE) begin
            cnt_q <= cnt_q - ONE;
            k_q   <= 1'b0;
          end else begin
            // cnt==1 is the last step; cnt==0 here is treated the same so it never wraps.
            cnt_q   <= '0;
            k_q     <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          cnt_q <= '0;
          k_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          k_q     <= 1'b0;
        end
      endcase
    end
  end

  assign K = k_q;

endmodule

// File: tb/tb_counter.sv
// Randomized bench for counter (N=8 and N=2 instances) against an
// elapsed-edges-since-load reference model.
module tb_counter;

  localparam int NA = 8;
  localparam int NB = 2;

  logic Clk, rst, load_a, load_b;
  logic k_a, k_b;

  int n_tests = 0;
  int n_fail  = 0;

  // edges since the last accepted load, saturating at N-1; -1 = no run since reset
  int since_a, since_b;

  counter #(.N(NA)) dut_a (.Clk(Clk), .rst(rst), .Load(load_a), .K(k_a));
  counter #(.N(NB)) dut_b (.Clk(Clk), .rst(rst), .Load(load_b), .K(k_b));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      since_a <= -1;
      since_b <= -1;
    end else begin
      if (load_a)                             since_a <= 0;
      else if (since_a >= 0 && since_a < NA-1) since_a <= since_a + 1;
      if (load_b)                             since_b <= 0;
      else if (since_b >= 0 && since_b < NB-1) since_b <= since_b + 1;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: K=%0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check both instances away from the rising edge, then drive the next inputs.
  task automatic step(input logic r, input logic la, input logic lb);
    @(negedge Clk);
    chk("k_n8", k_a, (since_a == NA-1));
    chk("k_n2", k_b, (since_b == NB-1));
    rst    = r;
    load_a = la;
    load_b = lb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic la, input logic lb);
    step(1'b0, la, lb);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; call right after step() at a falling edge.
  task automatic async_rst();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_n8", k_a, 1'b0);
    chk("async_rst_n2", k_b, 1'b0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_a = 1'b1; load_b = 1'b1;
    // Load toggling under reset must be ignored
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b0);
    idle(20);

    // basic run, held DONE
    pulse(1'b1, 1'b1); idle(17);
    // re-run from DONE
    pulse(1'b1, 1'b1); idle(10);
    // restart mid-run
    pulse(1'b1, 1'b1); idle(2); pulse(1'b1, 1'b0); idle(12);
    // async reset mid-run, stay idle, then a clean run
    pulse(1'b1, 1'b0); idle(3); async_rst(); idle(12);
    pulse(1'b1, 1'b1); idle(10);
    // held Load for 3 cycles
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1);
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 127) == 0) begin
        load_a = 1'b0; load_b = 1'b0;
        async_rst();
      end
    end
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
